// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair with bypassed direct writes and a multi-cycle multiply-accumulate engine
module hilo_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wr_hi_data,
  input  logic [DATA_W-1:0] wr_lo_data,
  input  logic              acc_valid,
  input  logic [1:0]        acc_op,
  input  logic [DATA_W-1:0] acc_a,
  input  logic [DATA_W-1:0] acc_b,
  output logic              acc_ready,
  input  logic              flush,
  output logic              busy,
  output logic              acc_done,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data
);
  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;
  state_t              state_q;
  logic [DATA_W-1:0]   a_q, b_q, hi_q, lo_q, hi_d, lo_d;
  logic [1:0]          op_q;
  logic [2*DATA_W-1:0] prod_q, prod_d, ext_a, ext_b, sum;
  logic                commit;
  // Operands are widened to 2*DATA_W so one truncated product covers both signed and unsigned modes
  always_comb begin
    ext_a  = op_q[0] ? {{DATA_W{1'b0}}, a_q} : {{DATA_W{a_q[DATA_W-1]}}, a_q};
    ext_b  = op_q[0] ? {{DATA_W{1'b0}}, b_q} : {{DATA_W{b_q[DATA_W-1]}}, b_q};
    prod_d = ext_a * ext_b;
    sum    = op_q[1] ? {hi_q, lo_q} - prod_q : {hi_q, lo_q} + prod_q;
    commit = (state_q == ACC) && !flush;
    hi_d   = wr_hi ? wr_hi_data : commit ? sum[2*DATA_W-1:DATA_W] : hi_q;
    lo_d   = wr_lo ? wr_lo_data : commit ? sum[DATA_W-1:0] : lo_q;
  end
  // Handshake and read ports are forced quiet while reset is held
  always_comb begin
    busy      = state_q != IDLE;
    acc_ready = rst && (state_q == IDLE) && !flush;
    acc_done  = commit;
    hi_data   = !rst ? '0 : wr_hi ? wr_hi_data : hi_q;
    lo_data   = !rst ? '0 : wr_lo ? wr_lo_data : lo_q;
  end
  // Accumulate sequencer: latch operands, multiply, then let the commit path update HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (acc_valid && !flush) begin
          a_q     <= acc_a;
          b_q     <= acc_b;
          op_q    <= acc_op;
          state_q <= MUL;
        end
        MUL: begin
          prod_q  <= prod_d;
          state_q <= flush ? IDLE : ACC;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // HI/LO accumulator: direct writes override the accumulate result per half
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed self-checking bench for hilo_unit
module tb_hilo_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_hi, wr_lo, acc_valid, flush;
  logic [31:0] wr_hi_data, wr_lo_data, acc_a, acc_b;
  logic [1:0]  acc_op;
  logic        acc_ready, busy, acc_done;
  logic [31:0] hi_data, lo_data;
  int          tests = 0;
  int          fails = 0;

  hilo_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_hi_data(wr_hi_data), .wr_lo_data(wr_lo_data),
    .acc_valid(acc_valid), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
    .acc_ready(acc_ready), .flush(flush), .busy(busy), .acc_done(acc_done),
    .hi_data(hi_data), .lo_data(lo_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_hl(input logic [31:0] h, input logic [31:0] l);
    wr_hi = 1'b1; wr_hi_data = h;
    wr_lo = 1'b1; wr_lo_data = l;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0;
  endtask

  task automatic do_acc(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    acc_valid = 1'b1; acc_op = op; acc_a = a; acc_b = b;
    #1 check({tag, "_ready"}, 64'(acc_ready), 64'd1);
    step();
    acc_valid = 1'b0;
    #1 check({tag, "_mul_busy"}, {62'd0, busy, acc_done}, 64'b10);
    step();
    check({tag, "_acc_busy_done"}, {62'd0, busy, acc_done}, 64'b11);
    step();
    check({tag, "_idle"}, {61'd0, busy, acc_done, acc_ready}, 64'b001);
    check({tag, "_result"}, {hi_data, lo_data}, exp);
  endtask

  initial begin
    rst = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_hi_data = '0; wr_lo_data = '0;
    acc_valid = 1'b0; acc_op = '0; acc_a = '0; acc_b = '0; flush = 1'b0;
    step();
    wr_hi = 1'b1; wr_hi_data = 32'hDEADBEEF;
    #1 check("reset_outputs", {hi_data, lo_data}, 64'd0);
    check("reset_flags", {61'd0, busy, acc_done, acc_ready}, 64'd0);
    step();
    wr_hi = 1'b0;
    rst = 1'b1;
    #1 check("ready_after_reset", 64'(acc_ready), 64'd1);
    check("reset_cleared", {hi_data, lo_data}, 64'd0);
    wr_hi = 1'b1; wr_hi_data = 32'h12345678;
    #1 check("bypass_hi", {hi_data, lo_data}, 64'h12345678_00000000);
    step();
    wr_hi = 1'b0;
    #1 check("hold_hi", {hi_data, lo_data}, 64'h12345678_00000000);

    set_hl(32'h0, 32'hFFFFFFFF);
    do_acc("carry", 2'b00, 32'd1, 32'd1, 64'h00000001_00000000);
    set_hl(32'h0, 32'h0);
    do_acc("madd_signed", 2'b00, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE);
    set_hl(32'h0, 32'h0);
    do_acc("maddu", 2'b01, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
    set_hl(32'h0, 32'h0);
    do_acc("msubu_wrap", 2'b11, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF);
    do_acc("msub_signed", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFE);

    set_hl(32'h0, 32'h0);
    acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'd3; acc_b = 32'd5;
    step();
    acc_valid = 1'b0;
    step();
    wr_lo = 1'b1; wr_lo_data = 32'hAA;
    #1 check("collide_bypass", 64'(lo_data), 64'hAA);
    step();
    wr_lo = 1'b0;
    #1 check("collide_result", {hi_data, lo_data}, 64'h00000000_000000AA);

    acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'd3; acc_b = 32'd5;
    step();
    acc_valid = 1'b0; flush = 1'b1;
    #1 check("flush_mul_done", {62'd0, busy, acc_done}, 64'b10);
    step();
    flush = 1'b0;
    #1 check("flush_idle", {61'd0, busy, acc_done, acc_ready}, 64'b001);
    step();
    check("flush_no_commit", {hi_data, lo_data}, 64'h00000000_000000AA);

    acc_valid = 1'b1; flush = 1'b1;
    #1 check("flush_idle_ready", 64'(acc_ready), 64'd0);
    step();
    acc_valid = 1'b0; flush = 1'b0;
    #1 check("flush_idle_reject", 64'(busy), 64'd0);

    set_hl(32'h0, 32'h0);
    acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'd2; acc_b = 32'd3;
    step();
    acc_valid = 1'b0; wr_hi = 1'b1; wr_hi_data = 32'h10;
    step();
    wr_hi = 1'b0;
    step();
    check("write_in_mul", {hi_data, lo_data}, 64'h00000010_00000006);

    set_hl(32'h5, 32'h7);
    acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'd1; acc_b = 32'd1;
    step();
    acc_valid = 1'b0;
    step();
    #2 rst = 1'b0;
    #1 check("async_reset_data", {hi_data, lo_data}, 64'd0);
    check("async_reset_flags", {61'd0, busy, acc_done, acc_ready}, 64'd0);
    step();
    rst = 1'b1;
    #1 check("post_reset_ready", {61'd0, busy, acc_done, acc_ready}, 64'b001);
    step();
    check("post_reset_no_commit", {hi_data, lo_data}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
